if_prefetch_stage: RTL and testbench

IF_PREFETCH_STAGE -- requirements
Module: if_prefetch_stage

---
 rtl/if_prefetch_stage.sv | 165 ++++++++++++++++
 tb/tb_if_prefetch_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch prefetch stage: credit-limited in-order fetch into a small {PC, IR} buffer with redirect flush.
// Optional build macro IF_PERF_CNT_EN adds perf_fetched / perf_flushed counters.
module if_prefetch_stage #(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_take_branch_out,
    input  logic [XLEN-1:0] ex_target_PC_out,
    input  logic            stall_en,
    output logic            proc2Imem_req,
    output logic [XLEN-1:0] proc2Imem_addr,
    input  logic            Imem2proc_ready,
    input  logic            Imem2proc_valid,
    input  logic [XLEN-1:0] Imem2proc_data,
    output logic            if_valid_inst_out,
    output logic [XLEN-1:0] if_PC_out,
    output logic [XLEN-1:0] if_NPC_out,
    output logic [XLEN-1:0] if_IR_out
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = CW + 1;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q,  resp_pc_d;
    logic [CW-1:0]   out_q,      out_d;
    logic [CW-1:0]   drop_q,     drop_d;
    logic [CW-1:0]   cnt_q,      cnt_d;
    logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;

    logic [XLEN-1:0] pc_mem [FIFO_DEPTH];
    logic [XLEN-1:0] ir_mem [FIFO_DEPTH];

    logic            credit_ok;
    logic            hs;
    logic            drop_resp;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] target_aligned;

    // Request side, decode side and handshake qualifiers
    always_comb begin
        credit_ok         = ({1'b0, cnt_q} + {1'b0, out_q}) < SW'(FIFO_DEPTH);
        proc2Imem_req     = credit_ok & ~ex_take_branch_out & ~rst;
        proc2Imem_addr    = fetch_pc_q & ~XLEN'(3);
        hs                = proc2Imem_req & Imem2proc_ready;
        target_aligned    = ex_target_PC_out & ~XLEN'(3);

        if_valid_inst_out = (cnt_q != '0) & ~ex_take_branch_out;
        pop               = if_valid_inst_out & ~stall_en;
        // A response in a redirect cycle belongs to the old path and is always discarded
        drop_resp         = Imem2proc_valid & (ex_take_branch_out | (drop_q != '0));
        push              = Imem2proc_valid & ~drop_resp;

        if_PC_out         = '0;
        if_NPC_out        = '0;
        if_IR_out         = '0;
        if (if_valid_inst_out) begin
            if_PC_out  = pc_mem[rd_ptr_q];
            if_NPC_out = pc_mem[rd_ptr_q] + XLEN'(4);
            if_IR_out  = ir_mem[rd_ptr_q];
        end
    end

    // Next-state for PCs, credit counters and buffer pointers
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        out_d      = out_q + CW'(hs) - CW'(Imem2proc_valid);
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (ex_take_branch_out) begin
            fetch_pc_d = target_aligned;
            resp_pc_d  = target_aligned;
            drop_d     = out_q - CW'(Imem2proc_valid);
            cnt_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (hs) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (drop_resp) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + XLEN'(4);
                wr_ptr_d  = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Buffer storage needs no reset; occupancy is tracked by cnt_q
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_mem[wr_ptr_q] <= resp_pc_q;
            ir_mem[wr_ptr_q] <= Imem2proc_data;
        end
    end

    // The credit rule keeps a full buffer from ever receiving a response
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            assert (cnt_q != CW'(FIFO_DEPTH));
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_flushed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_q + 32'(pop);
            perf_flushed_q <= perf_flushed_q
                              + 32'(ex_take_branch_out ? cnt_q : CW'(0))
                              + 32'(drop_resp);
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: directed scenarios plus random traffic against a program-order fetch/decode model.
module tb_if_prefetch_stage;

    localparam int unsigned     XLEN   = 32;
    localparam int unsigned     DEPTH  = 4;
    localparam logic [XLEN-1:0] RST_PC = '0;

    logic            clk = 1'b0;
    logic            rst, br, stall, ready, rvalid;
    logic [XLEN-1:0] tgt, rdata;
    logic            req, ivalid;
    logic [XLEN-1:0] addr, pc, npc, ir;
`ifdef IF_PERF_CNT_EN
    logic [31:0]     perf_fetched, perf_flushed;
`endif

    always #5 clk = ~clk;

    if_prefetch_stage #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk               (clk),
        .rst               (rst),
        .ex_take_branch_out(br),
        .ex_target_PC_out  (tgt),
        .stall_en          (stall),
        .proc2Imem_req     (req),
        .proc2Imem_addr    (addr),
        .Imem2proc_ready   (ready),
        .Imem2proc_valid   (rvalid),
        .Imem2proc_data    (rdata),
        .if_valid_inst_out (ivalid),
        .if_PC_out         (pc),
        .if_NPC_out        (npc),
        .if_IR_out         (ir)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched      (perf_fetched),
        .perf_flushed      (perf_flushed)
`endif
    );

    int              n_chk = 0;
    int              n_err = 0;
    int              cyc   = 0;
    int              lat;
    bit              resp_en;
    int              hs_cnt;
    logic [XLEN-1:0] mq_addr[$];
    int              mq_due[$];
    logic [XLEN-1:0] exp_fetch, exp_dec;
    logic            o_req, o_valid;
    logic [XLEN-1:0] o_addr, o_pc, o_ir;
    bit              ok;

    // Instruction memory contents: a fixed function of the word address
    function automatic logic [XLEN-1:0] imem(input logic [XLEN-1:0] a);
        return ~a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Program-order model: fetch addresses and decoded PCs each walk +4 from the last reset/redirect
    task automatic observe();
        o_req = req; o_addr = addr; o_valid = ivalid; o_pc = pc; o_ir = ir;
        if (rst) begin
            chk("req_in_reset", XLEN'(req), '0);
            exp_fetch = RST_PC;
            exp_dec   = RST_PC;
        end else if (br) begin
            chk("valid_on_redirect", XLEN'(ivalid), '0);
            chk("req_on_redirect", XLEN'(req), '0);
            exp_fetch = tgt & ~XLEN'(3);
            exp_dec   = tgt & ~XLEN'(3);
        end else begin
            if (req) begin
                chk("fetch_addr", addr, exp_fetch);
                if (ready) begin
                    mq_addr.push_back(addr);
                    mq_due.push_back(cyc + lat);
                    exp_fetch = exp_fetch + XLEN'(4);
                    hs_cnt++;
                end
            end
            if (ivalid) begin
                chk("dec_pc", pc, exp_dec);
                chk("dec_npc", npc, exp_dec + XLEN'(4));
                chk("dec_ir", ir, imem(exp_dec));
                if (!stall) exp_dec = exp_dec + XLEN'(4);
            end else begin
                chk("idle_pc", pc, '0);
                chk("idle_npc", npc, '0);
                chk("idle_ir", ir, '0);
            end
        end
    endtask

    // One clock: drive the in-order memory response, observe at negedge, advance past posedge
    task automatic cycle();
        if (resp_en && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            rvalid = 1'b1;
            rdata  = imem(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            rvalid = 1'b0;
            rdata  = '0;
        end
        @(negedge clk);
        observe();
        @(posedge clk);
        if (rst) begin
            mq_addr.delete();
            mq_due.delete();
        end
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; br = 1'b0; stall = 1'b0; ready = 1'b0; resp_en = 1'b1; lat = 1;
        cycle();
        rst = 1'b0;
        hs_cnt = 0;
    endtask

    task automatic wait_valid(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            cycle();
            if (o_valid) found = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1; br = 1'b0; tgt = '0; stall = 1'b0; ready = 1'b0;
        rvalid = 1'b0; rdata = '0; lat = 1; resp_en = 1'b1; hs_cnt = 0;
        exp_fetch = RST_PC; exp_dec = RST_PC;
        @(posedge clk); #1;

        // Streaming with 1-cycle memory: 0,4,8 requested, decoded back to back
        do_reset();
        ready = 1'b1;
        cycle(); chk("t1_reset_valid", XLEN'(o_valid), '0); chk("t1_reset_pc", o_pc, '0);
                 chk("t1_req0", XLEN'(o_req), XLEN'(1)); chk("t1_addr0", o_addr, 32'h0);
        cycle(); chk("t1_addr1", o_addr, 32'h4);
        cycle(); chk("t1_addr2", o_addr, 32'h8); chk("t1_pc0", o_pc, 32'h0);
        cycle(); chk("t1_pc1", o_pc, 32'h4);
        cycle(); chk("t1_pc2", o_pc, 32'h8); chk("t1_ir2", o_ir, imem(32'h8));

        // Stalled decode: credit allows exactly DEPTH requests, head holds
        do_reset();
        stall = 1'b1; ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        chk("t2_req_count", XLEN'(hs_cnt), XLEN'(DEPTH));
        chk("t2_req_off", XLEN'(o_req), '0);
        chk("t2_head_pc", o_pc, 32'h0);
        chk("t2_head_ir", o_ir, imem(32'h0));
        stall = 1'b0;
        for (int i = 0; i < 10; i++) cycle();

        // Memory not ready: address holds, then resumes at the held address
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t3_hold_req", XLEN'(o_req), XLEN'(1));
            chk("t3_hold_addr", o_addr, RST_PC);
        end
        ready = 1'b1;
        cycle(); chk("t3_resume_addr", o_addr, RST_PC);
        cycle(); chk("t3_next_addr", o_addr, RST_PC + 32'h4);
        for (int i = 0; i < 6; i++) cycle();

        // Redirect to 0x103 with two responses outstanding, none arriving that cycle
        do_reset();
        stall = 1'b1; ready = 1'b1;
        cycle();
        cycle();
        resp_en = 1'b0;
        cycle();
        ready = 1'b0; br = 1'b1; tgt = 32'h103;
        cycle();
        br = 1'b0; ready = 1'b1; resp_en = 1'b1; stall = 1'b0;
        cycle(); chk("t4_flushed", XLEN'(o_valid), '0); chk("t4_addr", o_addr, 32'h100);
        wait_valid(20, ok);
        chk("t4_timeout", XLEN'(ok), XLEN'(1));
        chk("t4_first_pc", o_pc, 32'h100);
        for (int i = 0; i < 6; i++) cycle();

        // Redirect coinciding with a response and a would-be pop
        do_reset();
        ready = 1'b1;
        cycle(); cycle(); cycle();
        br = 1'b1; tgt = 32'h200;
        cycle(); chk("t5_pop_suppressed", XLEN'(o_valid), '0);
        br = 1'b0;
        cycle(); chk("t5_addr", o_addr, 32'h200);
        wait_valid(20, ok);
        chk("t5_timeout", XLEN'(ok), XLEN'(1));
        chk("t5_first_pc", o_pc, 32'h200);

        // Back-to-back redirects: the later target wins
        lat = 2;
        cycle(); cycle();
        br = 1'b1; tgt = 32'h400; cycle();
        tgt = 32'h502; cycle();
        br = 1'b0;
        wait_valid(20, ok);
        chk("t6_timeout", XLEN'(ok), XLEN'(1));
        chk("t6_first_pc", o_pc, 32'h500);

        // Reset mid-stream with 3 entries buffered and noisy inputs
        do_reset();
        stall = 1'b1; ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        chk("t7_buffered", XLEN'(o_valid), XLEN'(1));
        rst = 1'b1; br = 1'b1; tgt = 32'h300;
        cycle();
        rst = 1'b0; br = 1'b0; stall = 1'b0;
        cycle(); chk("t7_valid_cleared", XLEN'(o_valid), '0);
                 chk("t7_req", XLEN'(o_req), XLEN'(1)); chk("t7_addr", o_addr, RST_PC);
        for (int i = 0; i < 8; i++) cycle();

        // Random traffic against the program-order model
        for (int i = 0; i < 2000; i++) begin
            rst   = ($urandom_range(0, 249) == 0);
            br    = !rst && ($urandom_range(0, 19) == 0);
            tgt   = $urandom();
            stall = ($urandom_range(0, 9) < 3);
            ready = ($urandom_range(0, 3) != 0);
            lat   = $urandom_range(1, 4);
            cycle();
        end
        rst = 1'b0; br = 1'b0; stall = 1'b0; ready = 1'b1;
        for (int i = 0; i < 12; i++) cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
